// File: rtl/queue_uart_tx.sv
// 8N1 UART transmitter that drains bytes from an upstream queue.
// One pop per frame; all outputs are registered so tx_o never glitches.
module queue_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       Clk_i,
    input  logic       Rst_i,
    input  logic       En_i,
    input  logic       q_empty_i,
    input  logic [7:0] q_data_i,
    output logic       q_en_o,
    output logic       q_rw_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {IDLE, POP, START, DATA, STOP} state_t;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] DONE_CNT = 16'(CLKS_PER_BIT - 2);

    state_t      state_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  shreg_q;
    logic        tx_q;
    logic        q_en_q;
    logic        busy_q;
    logic        done_q;

    assign q_rw_o = 1'b0;
    assign q_en_o = q_en_q;
    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            q_en_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            q_en_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    baud_q <= '0;
                    if (En_i && !q_empty_i) begin
                        state_q <= POP;
                        q_en_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                POP: begin
                    // q_data_i is valid while the pop strobe is high
                    shreg_q <= q_data_i;
                    state_q <= START;
                    tx_q    <= 1'b0;
                    baud_q  <= '0;
                end
                START: begin
                    if (baud_q == LAST_CNT) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shreg_q[0];
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_q == LAST_CNT) begin
                        baud_q  <= '0;
                        shreg_q <= {1'b0, shreg_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shreg_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                STOP: begin
                    // done_o is registered, so raise it one count early
                    done_q <= (baud_q == DONE_CNT);
                    if (baud_q == LAST_CNT) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/queue_uart_tx.md
QUEUE_UART_TX -- requirements
Module: queue_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port Clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port En_i, input, 1: drain enable; high permits starting a new frame.
REQ-005 SHALL have port q_empty_i, input, 1: empty flag from the upstream queue.
REQ-006 SHALL have port q_data_i, input, 8: queue read data, valid combinationally while a pop is asserted.
REQ-007 SHALL have port q_en_o, output, 1: queue access enable (pop strobe).
REQ-008 SHALL have port q_rw_o, output, 1: queue direction; constant 0 (read).
REQ-009 SHALL have port tx_o, output, 1: serial line; idles high.
REQ-010 SHALL have port busy_o, output, 1: high in every state except IDLE.
REQ-011 SHALL have port done_o, output, 1: one-cycle pulse at frame end.

Function
REQ-012 SHALL implement an FSM with states IDLE, POP, START, DATA and STOP.
REQ-013 SHALL encode frames as 8N1: start bit 0, 8 data bits LSB first, 1 stop bit, no parity.
REQ-014 SHALL, in IDLE with En_i=1 and q_empty_i=0 sampled at an edge, enter POP on that edge; otherwise SHALL remain in IDLE.
REQ-015 SHALL assert q_en_o=1 for exactly the one cycle spent in POP, and q_en_o=0 in all other states.
REQ-016 SHALL load q_data_i into an 8-bit shift register on the edge leaving POP, then enter START.
REQ-017 SHALL drive tx_o=0 for CLKS_PER_BIT cycles in START, then enter DATA with bit index 0.
REQ-018 SHALL, in DATA, drive tx_o = shift register bit 0 for CLKS_PER_BIT cycles per bit, then shift right by one and increment the bit index (3 bits).
REQ-019 SHALL leave DATA after bit index 7 completes and enter STOP.
REQ-020 SHALL drive tx_o=1 for CLKS_PER_BIT cycles in STOP, assert done_o in the last STOP cycle only, then return to IDLE.
REQ-021 SHALL drive tx_o=1 in IDLE and POP; tx_o SHALL be registered and glitch-free.
REQ-022 SHALL use a 16-bit baud counter counting 0..CLKS_PER_BIT-1, cleared on every state or bit change.
REQ-023 SHALL complete each byte in 10*CLKS_PER_BIT+1 cycles from POP entry to IDLE re-entry, with a minimum of 1 IDLE cycle between frames (back-to-back throughput of 10*CLKS_PER_BIT+2 cycles per byte).
REQ-024 SHALL complete the current frame if En_i falls mid-frame, then start no new frame.
REQ-025 SHALL ignore changes on q_empty_i outside IDLE.
REQ-026 SHALL never pop while q_empty_i=1; an underflow-free contract is mandatory.
REQ-027 SHALL hold q_rw_o=0 at all times, including during reset.

Reset
REQ-028 SHALL, on a clock edge with Rst_i=1, force state=IDLE, tx_o=1, q_en_o=0, busy_o=0, done_o=0, baud counter=0, bit index=0 and shift register=0x00.
REQ-029 SHALL abort any frame in progress on reset without popping further data; the aborted byte is lost.
REQ-030 SHALL give Rst_i priority over all other inputs.

Verification
REQ-031 SHALL be verified with CLKS_PER_BIT=4, queue holding 0xA5, En_i=1: exactly one q_en_o pulse, then tx_o = 0 | 1,0,1,0,0,1,0,1 | 1, each bit for 4 cycles; done_o pulses once; busy_o is high for 41 cycles.
REQ-032 SHALL be verified with q_empty_i=1 and En_i=1 for 100 cycles: q_en_o stays 0, tx_o stays 1, busy_o stays 0.
REQ-033 SHALL be verified with a queue holding 0x00, 0xFF, 0x3C back-to-back: three pops spaced 42 cycles apart, three frames bit-exact, three done_o pulses.
REQ-034 SHALL be verified with Rst_i=1 asserted for one cycle during DATA bit 3: next cycle tx_o=1, busy_o=0, state IDLE; with queue non-empty, the next pop occurs 2 cycles after Rst_i falls.
REQ-035 SHALL be verified with En_i dropped during START: the frame completes bit-exact, and no further q_en_o occurs although the queue is non-empty.
REQ-036 SHALL be verified with q_empty_i toggled randomly during a frame: no extra pops occur and tx_o is unaffected.
